// File: rtl/router_csr_pkg.sv
// Shared constants and state type for the router CSR AHB-Lite bridge.
package router_csr_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        ERR1,
        ERR2
    } bridge_state_t;

    function automatic logic htrans_active(input logic [1:0] trans);
        logic active;
        active = 1'b0;
        case (trans)
            HTRANS_NONSEQ, HTRANS_SEQ: active = 1'b1;
            HTRANS_IDLE, HTRANS_BUSY:  active = 1'b0;
        endcase
        return active;
    endfunction

endpackage

// File: rtl/router_csr_ahb_bridge.sv
// AHB-Lite slave front-end for router_csr: turns AHB address/data phases into
// single-cycle CSR strobes and reports CSR/decode errors as a two-cycle ERROR.
module router_csr_ahb_bridge
    import router_csr_pkg::*;
#(
    parameter int AWIDTH   = 32,
    parameter int DWIDTH   = 32,
    parameter int ERRCNT_W = 16
) (
    input  logic                i_hclk,
    input  logic                i_hreset,
    input  logic                i_hsel,
    input  logic [AWIDTH-1:0]   i_haddr,
    input  logic [1:0]          i_htrans,
    input  logic                i_hwrite,
    input  logic [2:0]          i_hsize,
    input  logic [DWIDTH-1:0]   i_hwdata,
    input  logic                i_hready,
    output logic                o_hreadyout,
    output logic                o_hresp,
    output logic [DWIDTH-1:0]   o_hrdata,
    output logic                o_csr_write,
    output logic                o_csr_read,
    output logic [AWIDTH-1:0]   o_csr_addr,
    output logic [DWIDTH-1:0]   o_csr_wdata,
    input  logic [DWIDTH-1:0]   i_csr_rdata,
    input  logic                i_csr_error,
    input  logic                i_csr_ready,
    output logic [ERRCNT_W-1:0] o_err_count
);

    bridge_state_t         r_state;
    bridge_state_t         w_next;
    logic [AWIDTH-1:0]     r_addr;
    logic                  r_write;
    logic [ERRCNT_W-1:0]   r_err_count;
    logic                  w_accept;
    logic                  w_legal;
    logic                  w_capture;
    bridge_state_t         w_accept_next;

    assign w_accept      = i_hsel & htrans_active(i_htrans) & i_hready;
    assign w_legal       = (i_hsize == HSIZE_WORD) & (i_haddr[1:0] == 2'b00);
    assign w_accept_next = !w_accept ? IDLE : (w_legal ? ACCESS : ERR1);

    assign o_csr_addr  = r_addr;
    assign o_err_count = r_err_count;

    always_ff @(posedge i_hclk or posedge i_hreset) begin
        if (i_hreset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_write     <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr  <= i_haddr;
                r_write <= i_hwrite;
            end
            if (w_next == ERR1 && r_err_count != '1) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        o_hreadyout = 1'b1;
        o_hresp     = 1'b0;
        o_hrdata    = '0;
        o_csr_read  = 1'b0;
        o_csr_write = 1'b0;
        o_csr_wdata = '0;
        case (r_state)
            IDLE, ERR2: begin
                o_hresp   = (r_state == ERR2);
                w_capture = w_accept;
                w_next    = w_accept_next;
            end
            ACCESS: begin
                // A CSR error still gets its strobe; the CSR side discards it.
                o_csr_read  = ~r_write & i_csr_ready;
                o_csr_write = r_write & i_csr_ready;
                o_csr_wdata = i_hwdata;
                o_hreadyout = i_csr_ready & ~i_csr_error;
                if (i_csr_ready && i_csr_error) begin
                    w_next = ERR1;
                end else if (i_csr_ready) begin
                    o_hrdata  = r_write ? '0 : i_csr_rdata;
                    w_capture = w_accept;
                    w_next    = w_accept_next;
                end
            end
            ERR1: begin
                o_hreadyout = 1'b0;
                o_hresp     = 1'b1;
                w_next      = ERR2;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_router_csr_ahb_bridge.sv
// Randomized AHB master + CSR stub bench for router_csr_ahb_bridge, checked
// against a transaction-level model of responses, latency and error count.
module tb_router_csr_ahb_bridge;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          hsel;
    logic [31:0]   haddr;
    logic [1:0]    htrans;
    logic          hwrite;
    logic [2:0]    hsize;
    logic [31:0]   hwdata;
    logic          hready;
    logic          hreadyout;
    logic          hresp;
    logic [31:0]   hrdata;
    logic          csr_write;
    logic          csr_read;
    logic [31:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic          csr_error;
    logic          csr_ready;
    logic [CW-1:0] err_count;
    logic          hready_block;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  stall;
        logic [3:0]  gap;
    } tx_t;

    tx_t         q[$];
    logic [31:0] ref_mem [64];
    int          err_total;
    logic [31:0] csr_mem [64];

    always #5 clk = ~clk;

    assign hready = hreadyout & ~hready_block;

    // CSR register-file stub: 64 words below 0x100, decode error above.
    assign csr_error = (csr_addr >= 32'h100);
    assign csr_rdata = csr_error ? 32'h0 : csr_mem[csr_addr[7:2]];
    always @(posedge clk) begin
        if (csr_write && !csr_error) csr_mem[csr_addr[7:2]] <= csr_wdata;
    end

    router_csr_ahb_bridge #(.AWIDTH(32), .DWIDTH(32), .ERRCNT_W(CW)) dut (
        .i_hclk(clk), .i_hreset(rst), .i_hsel(hsel), .i_haddr(haddr),
        .i_htrans(htrans), .i_hwrite(hwrite), .i_hsize(hsize), .i_hwdata(hwdata),
        .i_hready(hready), .o_hreadyout(hreadyout), .o_hresp(hresp),
        .o_hrdata(hrdata), .o_csr_write(csr_write), .o_csr_read(csr_read),
        .o_csr_addr(csr_addr), .o_csr_wdata(csr_wdata), .i_csr_rdata(csr_rdata),
        .i_csr_error(csr_error), .i_csr_ready(csr_ready), .o_err_count(err_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [31:0] d, input int st, input int g);
        tx_t t;
        t.addr = a; t.wr = w; t.size = s; t.wdata = d;
        t.stall = 4'(st); t.gap = 4'(g);
        q.push_back(t);
    endtask

    function automatic tx_t rand_tx();
        tx_t t;
        int  k;
        k       = $urandom_range(0, 9);
        t.addr  = 32'($urandom_range(0, 63)) << 2;
        if (k == 0) t.addr = 32'h100 + (32'($urandom_range(0, 3)) << 2);
        if (k == 1) t.addr = t.addr | 32'($urandom_range(1, 3));
        t.size  = (k == 2) ? 3'($urandom_range(0, 1)) : 3'b010;
        t.wr    = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        t.stall = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 3)) : 4'd0;
        t.gap   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 2)) : 4'd0;
        return t;
    endfunction

    // Expected outcome of one transfer, computed from the bus rules alone.
    task automatic complete(input tx_t t, input int cyc, input int strobes, input logic prev_resp);
        logic legal;
        logic cerr;
        logic err;
        int   exp_cyc;
        int   idx;
        legal   = (t.size == 3'b010) && (t.addr[1:0] == 2'b00);
        cerr    = legal && (t.addr >= 32'h100);
        err     = !legal || cerr;
        exp_cyc = !legal ? 2 : (cerr ? int'(t.stall) + 3 : int'(t.stall) + 1);
        idx     = int'(t.addr[7:2]);
        if (err) err_total++;
        check_eq("cycles", cyc, exp_cyc);
        check_eq("hresp", {31'b0, hresp}, {31'b0, err});
        if (cyc > 1) check_eq("hresp_first", {31'b0, prev_resp}, {31'b0, err});
        check_eq("strobes", strobes, legal ? 1 : 0);
        if (!err) begin
            if (t.wr) begin
                ref_mem[idx] = t.wdata;
                check_eq("hrdata_wr", hrdata, 32'h0);
            end else begin
                check_eq("hrdata", hrdata, ref_mem[idx]);
            end
        end
        check_eq("err_count", {28'b0, err_count}, (err_total > CNT_MAX) ? CNT_MAX : err_total);
    endtask

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = 32'h0; hwrite = 1'b0;
        hsize = 3'b010; hwdata = 32'h0; csr_ready = 1'b1;
    endtask

    // Pipelined master: called at posedge+1, returns at posedge+1.
    task automatic run_queue();
        tx_t  ap, dp;
        logic ap_v, dp_v, hr, prev_resp;
        int   dp_cycles, dp_strobes, stall, budget;
        ap = '0; dp = '0; ap_v = 1'b0; dp_v = 1'b0; hr = 1'b1; prev_resp = 1'b0;
        dp_cycles = 0; dp_strobes = 0; stall = 0; budget = 0;
        while (ap_v || dp_v || q.size() > 0) begin
            budget++;
            if (budget > 5000) begin
                check_eq("timeout", 32'd1, 32'd0);
                q.delete();
                break;
            end
            if (hr) begin
                dp = ap; dp_v = ap_v; dp_cycles = 0; dp_strobes = 0;
                stall = (dp.size == 3'b010 && dp.addr[1:0] == 2'b00) ? int'(dp.stall) : 0;
                ap_v = 1'b0;
                if (q.size() > 0) begin
                    if (q[0].gap > 0) q[0].gap = q[0].gap - 4'd1;
                    else begin ap = q.pop_front(); ap_v = 1'b1; end
                end
            end
            if (ap_v) begin
                hsel = 1'b1; htrans = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                haddr = ap.addr; hwrite = ap.wr; hsize = ap.size;
            end else begin
                case ($urandom_range(0, 2))
                    0:       begin hsel = 1'b0; htrans = 2'($urandom_range(0, 3)); end
                    1:       begin hsel = 1'b1; htrans = 2'b00; end
                    default: begin hsel = 1'b1; htrans = 2'b01; end
                endcase
                haddr = $urandom; hwrite = 1'($urandom_range(0, 1)); hsize = 3'b010;
            end
            hwdata    = dp_v ? dp.wdata : $urandom;
            csr_ready = !(dp_v && stall > 0);
            @(negedge clk);
            if (dp_v) begin
                dp_cycles++;
                if (csr_read || csr_write) begin
                    dp_strobes++;
                    check_eq("strobe_addr", csr_addr, dp.addr);
                    check_eq("strobe_dir", {31'b0, csr_write}, {31'b0, dp.wr});
                    if (dp.wr) check_eq("strobe_wdata", csr_wdata, dp.wdata);
                end
                if (hreadyout) complete(dp, dp_cycles, dp_strobes, prev_resp);
                if (stall > 0) stall--;
            end else begin
                check_eq("idle_okay", {28'b0, hreadyout, hresp, csr_read, csr_write}, 32'h8);
            end
            prev_resp = hresp;
            hr = hready;
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    initial begin
        rst = 1'b1; hready_block = 1'b0; err_total = 0;
        drive_idle();
        for (int i = 0; i < 64; i++) begin
            csr_mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_hreadyout", {31'b0, hreadyout}, 32'h1);
        check_eq("rst_hresp", {31'b0, hresp}, 32'h0);
        check_eq("rst_strobes", {30'b0, csr_read, csr_write}, 32'h0);
        check_eq("rst_hrdata", hrdata, 32'h0);
        check_eq("rst_csr_addr", csr_addr, 32'h0);
        check_eq("rst_err_count", {28'b0, err_count}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        push(32'h8, 1'b1, 3'b010, 32'hDEADBEEF, 0, 0);
        push(32'h8, 1'b0, 3'b010, 32'h0, 0, 0);
        push(32'h0, 1'b1, 3'b010, 32'h11110000, 0, 1);
        push(32'h4, 1'b1, 3'b010, 32'h22224444, 0, 0);
        push(32'h8, 1'b1, 3'b010, 32'h33338888, 0, 0);
        push(32'h100, 1'b0, 3'b010, 32'h0, 0, 1);
        push(32'h0, 1'b0, 3'b010, 32'h0, 0, 0);
        push(32'h6, 1'b0, 3'b010, 32'h0, 0, 1);
        push(32'h0, 1'b0, 3'b001, 32'h0, 0, 0);
        push(32'h8, 1'b0, 3'b010, 32'h0, 3, 1);
        run_queue();

        repeat (300) q.push_back(rand_tx());
        run_queue();

        repeat (CNT_MAX + 2) push(32'h4, 1'b1, 3'b000, 32'h0, 0, 0);
        run_queue();
        check_eq("err_saturated", {28'b0, err_count}, CNT_MAX);

        hready_block = 1'b1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'b010;
        @(negedge clk);
        check_eq("blk_ready", {31'b0, hreadyout}, 32'h1);
        @(posedge clk); #1;
        hready_block = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check_eq("blk_no_strobe", {30'b0, csr_read, csr_write}, 32'h0);
        check_eq("blk_idle_ready", {31'b0, hreadyout}, 32'h1);
        @(posedge clk); #1;

        hsel = 1'b1; htrans = 2'b10; haddr = 32'h10; hwrite = 1'b0; hsize = 3'b010;
        csr_ready = 1'b0;
        @(posedge clk); #1;
        htrans = 2'b00;
        @(negedge clk);
        check_eq("rst_mid_wait", {31'b0, hreadyout}, 32'h0);
        #1 rst = 1'b1;
        #1;
        check_eq("rst_mid_ready", {31'b0, hreadyout}, 32'h1);
        check_eq("rst_mid_strobes", {30'b0, csr_read, csr_write}, 32'h0);
        check_eq("rst_mid_count", {28'b0, err_count}, 32'h0);
        err_total = 0;
        @(posedge clk); #1;
        rst = 1'b0; csr_ready = 1'b1;
        @(negedge clk);
        check_eq("rst_after_idle", {29'b0, hreadyout, csr_read, csr_write}, 32'h4);
        @(posedge clk); #1;

        push(32'h100, 1'b0, 3'b010, 32'h0, 0, 0);
        push(32'h8, 1'b0, 3'b010, 32'h0, 0, 0);
        run_queue();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
